// File: rtl/bnn_neuron_seq_if.sv
// bnn_neuron_seq_if: activation-slice input and result output handshakes.
// Signals: in_valid/in_ready/in_data (slices in), out_valid/out_ready/axon/count (result out).
interface bnn_neuron_seq_if #(
    parameter int CHUNK    = 4,
    parameter int ACC_BITS = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [CHUNK-1:0]    in_data;
    logic                out_valid;
    logic                out_ready;
    logic                axon;
    logic [ACC_BITS-1:0] count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, axon, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, axon, count
    );
endinterface

// File: rtl/bnn_neuron_seq.sv
// bnn_neuron_seq: time-multiplexed binary neuron, CHUNK-bit slices, serial param chain.
// Ports: i_clk, i_rst_n (sync, active-low), i_setup, i_param_in, o_param_out,
//        io (bnn_neuron_seq_if.slave: slice input and result output handshakes).
// Option: BNN_NEURON_XNOR_EN selects XNOR synapses (match count); default is AND.
module bnn_neuron_seq #(
    parameter int INPUTS    = 16,
    parameter int CHUNK     = 4,
    parameter int BIAS_BITS = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_setup,
    input  logic            i_param_in,
    output logic            o_param_out,
    bnn_neuron_seq_if.slave io
);
    localparam int ACC_BITS = $clog2(INPUTS + 1);
    localparam int NCHUNK   = INPUTS / CHUNK;
    localparam int IDX_BITS = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CHAIN    = INPUTS + BIAS_BITS;
    localparam int CMP_BITS = (ACC_BITS > BIAS_BITS) ? ACC_BITS : BIAS_BITS;

    typedef enum logic {S_ACC, S_OUT} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    // chain[0] = weights[0] ... chain[CHAIN-1] = bias MSB
    logic [CHAIN-1:0]     r_chain;
    logic [ACC_BITS-1:0]  r_acc;
    logic [ACC_BITS-1:0]  r_count;
    logic [IDX_BITS-1:0]  r_idx;
    logic                 r_axon;

    logic [INPUTS-1:0]    w_weights;
    logic [BIAS_BITS-1:0] w_bias;
    logic [CHUNK-1:0]     w_wslice;
    logic [CHUNK-1:0]     w_syn;
    logic [ACC_BITS-1:0]  w_pop;
    logic [ACC_BITS-1:0]  w_sum;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_gt;

    assign w_weights = r_chain[INPUTS-1:0];
    assign w_bias    = r_chain[CHAIN-1 -: BIAS_BITS];
    assign w_wslice  = w_weights[int'(r_idx)*CHUNK +: CHUNK];

`ifdef BNN_NEURON_XNOR_EN
    assign w_syn = ~(w_wslice ^ io.in_data);
`else
    assign w_syn = w_wslice & io.in_data;
`endif

    always_comb begin
        w_pop = '0;
        for (int b = 0; b < CHUNK; b++) begin
            w_pop = w_pop + ACC_BITS'(w_syn[b]);
        end
    end

    assign w_sum    = r_acc + w_pop;
    assign w_last   = (r_idx == IDX_BITS'(NCHUNK - 1));
    assign w_gt     = CMP_BITS'(w_sum) > CMP_BITS'(w_bias);
    // Same condition as in_ready && in_valid, kept free of the FSM block.
    assign w_accept = io.in_valid && (r_state == S_ACC) && !i_setup;

    assign o_param_out = r_chain[CHAIN-1];
    assign io.axon     = r_axon;
    assign io.count    = r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        io.in_ready  = 1'b0;
        io.out_valid = 1'b0;
        unique case (r_state)
            S_ACC: begin
                io.in_ready = !i_setup;
                if (w_accept && w_last) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                io.out_valid = 1'b1;
                if (io.out_ready) begin
                    w_state_nxt = S_ACC;
                end
            end
            default: w_state_nxt = S_ACC;
        endcase
        // Parameter shifting aborts any evaluation in progress.
        if (i_setup) begin
            w_state_nxt = S_ACC;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_chain <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_axon  <= 1'b0;
        end else if (i_setup) begin
            r_chain <= {r_chain[CHAIN-2:0], i_param_in};
            r_acc   <= '0;
            r_idx   <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_count <= w_sum;
                r_axon  <= w_gt;
                r_acc   <= '0;
                r_idx   <= '0;
            end else begin
                r_acc   <= w_sum;
                r_idx   <= r_idx + IDX_BITS'(1);
            end
        end
    end
endmodule

// File: tb/tb_bnn_neuron_seq.sv
// tb_bnn_neuron_seq: directed bench for bnn_neuron_seq, INPUTS=8 CHUNK=4 BIAS_BITS=3.
// Prints one "passed/total checks passed" summary line.
module tb_bnn_neuron_seq;
    logic clk;
    logic rst_n;
    logic setup;
    logic param_in;
    logic param_out;
    int   n_chk;
    int   n_pass;

    bnn_neuron_seq_if #(.CHUNK(4), .ACC_BITS(4)) nif ();

    bnn_neuron_seq #(
        .INPUTS   (8),
        .CHUNK    (4),
        .BIAS_BITS(3)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_setup    (setup),
        .i_param_in (param_in),
        .o_param_out(param_out),
        .io         (nif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Bias MSB first, then weights MSB first: v = {bias[2:0], weights[7:0]}.
    task automatic load(input logic [10:0] v);
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            setup    = 1'b1;
            param_in = v[i];
        end
        @(negedge clk);
        setup = 1'b0;
    endtask

    task automatic send(input logic [3:0] d);
        @(negedge clk);
        nif.in_valid = 1'b1;
        nif.in_data  = d;
        @(negedge clk);
        nif.in_valid = 1'b0;
    endtask

    initial begin
        n_chk         = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        setup         = 1'b0;
        param_in      = 1'b0;
        nif.in_valid  = 1'b0;
        nif.in_data   = '0;
        nif.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_out_valid", nif.out_valid, 0);
        check("rst_axon", nif.axon, 0);
        check("rst_count", nif.count, 0);
        check("rst_param_out", param_out, 0);
        check("rst_in_ready", nif.in_ready, 1);
        rst_n = 1'b1;

        // bias=3, weights=FF
        load(11'b011_11111111);
        check("load_param_out", param_out, 0);
        send(4'b1111);
        check("mid_out_valid", nif.out_valid, 0);
        send(4'b0001);
        check("thr_out_valid", nif.out_valid, 1);
        check("thr_count", nif.count, 5);
        check("thr_axon", nif.axon, 1);
        check("thr_in_ready", nif.in_ready, 0);
        @(negedge clk);
        check("thr_pop_valid", nif.out_valid, 0);
        check("thr_hold_count", nif.count, 5);

        // count == bias gives axon=0
        send(4'b0011);
        send(4'b0001);
        check("eq_count", nif.count, 3);
        check("eq_axon", nif.axon, 0);
        @(negedge clk);
        check("eq_pop_valid", nif.out_valid, 0);

        // backpressure
        nif.out_ready = 1'b0;
        send(4'b1111);
        send(4'b1111);
        check("bp_count", nif.count, 8);
        check("bp_axon", nif.axon, 1);
        nif.in_valid = 1'b1;
        nif.in_data  = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_in_ready", nif.in_ready, 0);
            check("bp_out_valid", nif.out_valid, 1);
            check("bp_count_hold", nif.count, 8);
            check("bp_axon_hold", nif.axon, 1);
        end
        nif.out_ready = 1'b1;
        nif.in_valid  = 1'b0;
        @(negedge clk);
        check("bp_release", nif.out_valid, 0);
        check("bp_ready_back", nif.in_ready, 1);
        send(4'b0001);
        send(4'b0000);
        check("bp_next_valid", nif.out_valid, 1);
        check("bp_next_count", nif.count, 1);
        check("bp_next_axon", nif.axon, 0);
        @(negedge clk);

        // setup mid-evaluation: shift in a 1 -> weights FF, bias 7
        send(4'b1111);
        @(negedge clk);
        setup    = 1'b1;
        param_in = 1'b1;
        #1;
        check("su_in_ready", nif.in_ready, 0);
        @(negedge clk);
        setup = 1'b0;
        check("su_param_out", param_out, 1);
        check("su_out_valid", nif.out_valid, 0);
        send(4'b1111);
        check("su_restart", nif.out_valid, 0);
        send(4'b0000);
        check("su_out_valid2", nif.out_valid, 1);
        check("su_count", nif.count, 4);
        check("su_axon", nif.axon, 0);
        @(negedge clk);

        // synapse type: weights 0F, bias 0, zero activations
        load(11'b000_00001111);
        check("mac_param_out", param_out, 0);
        send(4'b0000);
        send(4'b0000);
        check("mac_valid", nif.out_valid, 1);
`ifdef BNN_NEURON_XNOR_EN
        check("mac_count", nif.count, 4);
        check("mac_axon", nif.axon, 1);
`else
        check("mac_count", nif.count, 0);
        check("mac_axon", nif.axon, 0);
`endif
        @(negedge clk);
        check("mac_pop", nif.out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
